// File: rtl/multicycle_control_pkg.sv
// -----------------------------------------------------------------------------
// mc_pkg
// Shared definitions for the multi-cycle MIPS control unit:
//   - state_t      : sequencing states of the control FSM
//   - OP_*         : 6-bit primary opcodes recognised by the decoder
//   - SRCB_*       : alu_src_b mux encodings
//   - PCSRC_*      : pc_source mux encodings
//   - ALUOP_*      : alu_op encodings (zero-extended to ALUOP_W at the top)
//   - LSZ_*        : load_size encodings
//   - ctrl_t       : bundle of per-state datapath controls
// -----------------------------------------------------------------------------
package mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_MEM_WB    = 4'd6,
    S_EXEC_R    = 4'd7,
    S_R_WB      = 4'd8,
    S_EXEC_I    = 4'd9,
    S_I_WB      = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12,
    S_ILLEGAL   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'd0;
  localparam logic [1:0] ALUOP_SUB    = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT  = 2'd2;

  localparam logic [1:0] LSZ_WORD     = 2'b00;
  localparam logic [1:0] LSZ_HALF_S   = 2'b01;
  localparam logic [1:0] LSZ_HALF_U   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_if
// Bundle between the control unit and the shared datapath.
//   opcode, mem_ready           : datapath -> control
//   pc/ir/mem/reg/alu controls  : control -> datapath
//   load_size, illegal_op       : control -> datapath
//   instr_count                 : retired-instruction counter
// modport master = control unit side, modport slave = datapath side.
// Parameters must match those of the multicycle_control instance.
// -----------------------------------------------------------------------------
interface multicycle_control_if #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 2,
  parameter int CNT_W    = 32
);
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                pc_write;
  logic                pc_write_cond;
  logic                ir_write;
  logic                i_or_d;
  logic                mem_read;
  logic                mem_write;
  logic                mem_to_reg;
  logic                reg_dst;
  logic                reg_write;
  logic                alu_src_a;
  logic [1:0]          alu_src_b;
  logic [1:0]          pc_source;
  logic [ALUOP_W-1:0]  alu_op;
  logic [1:0]          load_size;
  logic                illegal_op;
  logic [CNT_W-1:0]    instr_count;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
           alu_op, load_size, illegal_op, instr_count
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
           alu_op, load_size, illegal_op, instr_count
  );
endinterface

// File: rtl/multicycle_control_output_decode.sv
// -----------------------------------------------------------------------------
// mc_output_decode
// Combinational per-state output table of the multi-cycle control unit.
//   i_state     : current FSM state
//   i_mem_ready : memory handshake (only used for FETCH ir_write/pc_write)
//   o_ctrl      : datapath control bundle
// Everything except the FETCH write enables depends only on the registered
// state, so those outputs are glitch-free relative to the clock edge.
// -----------------------------------------------------------------------------
module mc_output_decode
  import mc_pkg::*;
(
  input  state_t i_state,
  input  logic   i_mem_ready,
  output ctrl_t  o_ctrl
);

  // Default every control to 0 so each state only lists what it asserts.
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRCB_FOUR;
        // IR and PC only update on the cycle the instruction word arrives.
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      S_DECODE: begin
        o_ctrl.alu_src_b = SRCB_IMM_SH2;
      end
      S_MEM_ADDR, S_EXEC_I: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WRITE: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.i_or_d    = 1'b1;
      end
      S_MEM_WB: begin
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.reg_write  = 1'b1;
      end
      S_EXEC_R: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        o_ctrl.reg_dst   = 1'b1;
        o_ctrl.reg_write = 1'b1;
      end
      S_I_WB: begin
        o_ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_op        = ALUOP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PCSRC_JUMP;
      end
      S_ILLEGAL: begin
        o_ctrl.illegal_op = 1'b1;
      end
      default: begin
        o_ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
// Multi-cycle MIPS control unit: sequences fetch, decode, execute, memory and
// write-back, stalls on mem_ready, traps unsupported opcodes and counts
// retired instructions.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset (returns to IDLE, all outputs 0)
//   io_bus : control-unit side of multicycle_control_if (opcode/mem_ready in,
//            datapath controls, load_size, illegal_op, instr_count out)
// -----------------------------------------------------------------------------
module multicycle_control
  import mc_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 2,
  parameter int CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master io_bus
);

  state_t              r_state;
  state_t              w_next_state;
  logic [1:0]          r_load_size;
  logic [CNT_W-1:0]    r_instr_count;
  logic [OPCODE_W-1:0] w_opcode;
  logic                w_mem_ready;
  logic                w_retire;
  ctrl_t               w_ctrl;

  assign w_opcode    = io_bus.opcode;
  assign w_mem_ready = io_bus.mem_ready;

  // Full-width compare: any set bit above bit 5 prevents a match, which
  // routes the instruction to ILLEGAL.
  function automatic logic op_is(input logic [OPCODE_W-1:0] op,
                                 input logic [5:0]          code);
    return op == OPCODE_W'(code);
  endfunction

  // Next-state logic; memory states wait for the handshake.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   w_next_state = S_FETCH;
      S_FETCH:  if (w_mem_ready) w_next_state = S_DECODE;
      S_DECODE: begin
        if (op_is(w_opcode, OP_RTYPE))
          w_next_state = S_EXEC_R;
        else if (op_is(w_opcode, OP_ADDI))
          w_next_state = S_EXEC_I;
        else if (op_is(w_opcode, OP_LW) || op_is(w_opcode, OP_LH) ||
                 op_is(w_opcode, OP_LHU) || op_is(w_opcode, OP_SW))
          w_next_state = S_MEM_ADDR;
        else if (op_is(w_opcode, OP_BEQ))
          w_next_state = S_BRANCH;
        else if (op_is(w_opcode, OP_J))
          w_next_state = S_JUMP;
        else
          w_next_state = S_ILLEGAL;
      end
      // The IR still holds the opcode here, so it selects load vs store.
      S_MEM_ADDR:  w_next_state = op_is(w_opcode, OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (w_mem_ready) w_next_state = S_MEM_WB;
      S_MEM_WRITE: if (w_mem_ready) w_next_state = S_FETCH;
      S_EXEC_R:    w_next_state = S_R_WB;
      S_EXEC_I:    w_next_state = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_ILLEGAL:
                   w_next_state = S_FETCH;
      default:     w_next_state = S_IDLE;
    endcase
  end

  // An instruction retires on the edge leaving its final state; a store's
  // final state can stall, so it only retires on the ready cycle.
  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      S_R_WB, S_I_WB, S_MEM_WB, S_BRANCH, S_JUMP: w_retire = 1'b1;
      S_MEM_WRITE: w_retire = w_mem_ready;
      default:     w_retire = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // load_size is captured once per instruction in DECODE and held after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_size <= LSZ_WORD;
    end else if (r_state == S_DECODE) begin
      if (op_is(w_opcode, OP_LH))       r_load_size <= LSZ_HALF_S;
      else if (op_is(w_opcode, OP_LHU)) r_load_size <= LSZ_HALF_U;
      else                              r_load_size <= LSZ_WORD;
    end
  end

  // Retired-instruction counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_instr_count <= '0;
    else if (w_retire) r_instr_count <= r_instr_count + CNT_W'(1);
  end

  mc_output_decode u_output_decode (
    .i_state     (r_state),
    .i_mem_ready (w_mem_ready),
    .o_ctrl      (w_ctrl)
  );

  assign io_bus.pc_write      = w_ctrl.pc_write;
  assign io_bus.pc_write_cond = w_ctrl.pc_write_cond;
  assign io_bus.ir_write      = w_ctrl.ir_write;
  assign io_bus.i_or_d        = w_ctrl.i_or_d;
  assign io_bus.mem_read      = w_ctrl.mem_read;
  assign io_bus.mem_write     = w_ctrl.mem_write;
  assign io_bus.mem_to_reg    = w_ctrl.mem_to_reg;
  assign io_bus.reg_dst       = w_ctrl.reg_dst;
  assign io_bus.reg_write     = w_ctrl.reg_write;
  assign io_bus.alu_src_a     = w_ctrl.alu_src_a;
  assign io_bus.alu_src_b     = w_ctrl.alu_src_b;
  assign io_bus.pc_source     = w_ctrl.pc_source;
  assign io_bus.alu_op        = ALUOP_W'(w_ctrl.alu_op);
  assign io_bus.illegal_op    = w_ctrl.illegal_op;
  assign io_bus.load_size     = r_load_size;
  assign io_bus.instr_count   = r_instr_count;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Parametrised multi-cycle MIPS control unit. It replaces the single-cycle opcode decoder with a Moore-style state machine that sequences fetch, decode, execute, memory and write-back over 3–5 cycles. It stalls on a memory-ready handshake, adds a `j` jump and illegal-opcode trapping, and keeps a retired-instruction counter. It sits between the instruction register (opcode source) and the shared datapath (PC, memory port, register file, ALU muxes).

## Interface
- `OPCODE_W`, default 6: opcode width. Must be ≥ 6.
- `ALUOP_W`, default 2: `alu_op` width. Must be ≥ 2; encodings are zero-extended.
- `CNT_W`, default 32: width of the retired-instruction counter.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  OPCODE_W  IR[31:26]; valid from DECODE onward.
- `mem_ready`  in  1  memory completes the current read/write this cycle.
- `pc_write`, `pc_write_cond`, `ir_write`, `i_or_d`, `mem_read`, `mem_write`, `mem_to_reg`, `reg_dst`, `reg_write`, `alu_src_a`  out  1 each  datapath controls.
- `alu_src_b`  out  2  00 = reg B, 01 = constant 4, 10 = sign-ext imm, 11 = imm<<2.
- `pc_source`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alu_op`  out  ALUOP_W  0 = add, 1 = sub, 2 = funct-decoded.
- `load_size`  out  2  00 = word, 01 = half signed, 10 = half unsigned.
- `illegal_op`  out  1  one-cycle pulse on an unsupported opcode.
- `instr_count`  out  CNT_W  retired instructions; wraps modulo 2^CNT_W.

## Operation
- States and transitions:
  - IDLE → FETCH.
  - FETCH → DECODE when `mem_ready`.
  - DECODE → next state by opcode:
    - 0x00 → EXEC_R → R_WB.
    - 0x08 → EXEC_I → I_WB.
    - 0x23 / 0x21 / 0x25 → MEM_ADDR → MEM_READ → MEM_WB.
    - 0x2B → MEM_ADDR → MEM_WRITE.
    - 0x04 → BRANCH.
    - 0x02 → JUMP.
    - anything else → ILLEGAL.
  - MEM_READ and MEM_WRITE hold until `mem_ready`.
  - R_WB, I_WB, MEM_WB, MEM_WRITE (on ready), BRANCH, JUMP and ILLEGAL all return to FETCH.
- Outputs per state. Any signal not listed is 0.
  - IDLE: all 0.
  - FETCH: `mem_read`=1, `alu_src_b`=01, `ir_write` = `pc_write` = `mem_ready`.
  - DECODE: `alu_src_b`=11.
  - MEM_ADDR and EXEC_I: `alu_src_a`=1, `alu_src_b`=10.
  - MEM_READ: `mem_read`=1, `i_or_d`=1.
  - MEM_WRITE: `mem_write`=1, `i_or_d`=1.
  - MEM_WB: `mem_to_reg`=1, `reg_write`=1.
  - EXEC_R: `alu_src_a`=1, `alu_op`=2.
  - R_WB: `reg_dst`=1, `reg_write`=1.
  - I_WB: `reg_write`=1.
  - BRANCH: `alu_src_a`=1, `alu_op`=1, `pc_write_cond`=1, `pc_source`=01.
  - JUMP: `pc_write`=1, `pc_source`=10.
  - ILLEGAL: `illegal_op`=1.
- `load_size` is a register loaded in DECODE:
  - 0x21 loads 01, 0x25 loads 10, all other opcodes load 00.
  - It holds until the next DECODE.
- `instr_count` increments by 1 on the exit edge of R_WB, I_WB, MEM_WB, BRANCH and JUMP, and on MEM_WRITE when `mem_ready`=1.
  - ILLEGAL does not count.
  - The counter wraps from all-ones to 0.
- Opcode bits above bit 5 must be 0 for a match; otherwise the instruction is ILLEGAL.

## Timing
- Reset: state = IDLE, `load_size` = 00, `instr_count` = 0, so every output is 0.
  - Reset asserted mid-instruction aborts it immediately, asynchronously. No partial `reg_write`/`mem_write` is held.
- First FETCH occurs in the second cycle after `rst_n` rises.
- Cycles per instruction with zero wait:
  - R-type and addi: 4.
  - lw / lh / lhu: 5.
  - sw: 4.
  - beq and j: 3.
  - Illegal: 3.
- Each cycle with `mem_ready`=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle. During that cycle all controls stay stable and `ir_write`/`pc_write` stay 0.
- `mem_ready` is ignored in every other state.
- All outputs except FETCH `ir_write`/`pc_write` are pure functions of registered state, so they are glitch-free relative to the clock edge.

## Structure
- Package `mc_pkg` holds:
  - the state enum;
  - opcode localparams (OP_RTYPE, OP_ADDI, OP_LW, OP_LH, OP_LHU, OP_SW, OP_BEQ, OP_J);
  - `alu_src_b`, `pc_source`, `alu_op` and `load_size` encodings.
- One combinational sub-module, `mc_output_decode` (state, `mem_ready` → control bundle), keeps the FSM/counter top separate from the output table.

## Test plan
- Reset held, then `rst_n` rises with `opcode`=0x00 and `mem_ready`=1 → IDLE, FETCH, DECODE, EXEC_R, R_WB. `reg_write`=1 and `reg_dst`=1 only in cycle 5; `instr_count`=1 afterwards.
- lh (0x21) with `mem_ready` low for 2 cycles in MEM_READ → 7-cycle instruction. `load_size`=01 from DECODE+1; `mem_to_reg`=1 only in MEM_WB.
- sw (0x2B) → `mem_write`=1 exactly in MEM_WRITE. `reg_write` never asserts; count increments on the ready cycle.
- beq (0x04) then j (0x02) → `pc_write_cond`=1 with `pc_source`=01, then `pc_write`=1 with `pc_source`=10. Six cycles total; count +2.
- Opcode 0x3F and opcode 0x48 (bit 6 set with `OPCODE_W`=7) → `illegal_op` pulses once in cycle 3; `instr_count` unchanged; FETCH follows.
- `CNT_W`=4: retire 16 addi → `instr_count` wraps 15→0. Then `rst_n` pulsed low mid-MEM_READ → all outputs 0 asynchronously; count = 0.
